// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forwarding, stall/flush control, hazard FSM, perf counters and a memory-wait watchdog for a 5-stage pipeline
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic        mem_busy,
  input  logic        cnt_clr,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        StallW,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        timeout
);
  typedef enum logic [1:0] {RUN = 2'b00, LDSTALL = 2'b01, REDIRECT = 2'b10, MEMWAIT = 2'b11} state_t;
  state_t      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [7:0]  wait_q, wait_d;
  logic        timeout_q, timeout_d;
  logic        lw_stall, stall_front, stall_back;
  assign lw_stall = ResultSrcE == 2'b01 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
  always_comb begin
    ForwardAE = reset ? 2'b00
              : (RegWriteM && RdM != 5'd0 && RdM == Rs1E) ? 2'b10
              : (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ? 2'b01 : 2'b00;
    ForwardBE = reset ? 2'b00
              : (RegWriteM && RdM != 5'd0 && RdM == Rs2E) ? 2'b10
              : (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ? 2'b01 : 2'b00;
  end
  // A busy memory freezes every stage, so branch/load decisions wait until Execute moves again.
  always_comb begin
    stall_back  = !reset && mem_busy;
    stall_front = !reset && (mem_busy || (!PCSrcE && lw_stall));
    StallF      = stall_front;
    StallD      = stall_front;
    StallE      = stall_back;
    StallM      = stall_back;
    StallW      = stall_back;
    FlushD      = reset || (!mem_busy && PCSrcE);
    FlushE      = reset || (!mem_busy && (PCSrcE || lw_stall));
  end
  always_comb begin
    state_d     = mem_busy ? MEMWAIT : PCSrcE ? REDIRECT : lw_stall ? LDSTALL : RUN;
    stall_cnt_d = cnt_clr ? 16'd0 : (StallF && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    flush_cnt_d = cnt_clr ? 16'd0 : (FlushE && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
    wait_d      = !mem_busy ? 8'd0 : (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
    timeout_d   = cnt_clr ? 1'b0 : timeout_q || wait_d == 8'hFF;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
      wait_q      <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
    end
  end
  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign timeout   = timeout_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: randomized and directed checks of pipeline_hazard_ctrl against a behavioural model
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, PCSrcE, mem_busy, cnt_clr;
  logic [1:0] ResultSrcE;
  logic [1:0] ForwardAE, ForwardBE, state;
  logic StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, timeout;
  logic [15:0] stall_cnt, flush_cnt;
  wire [6:0] ctl = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE};
  int cmp = 0, errs = 0;
  int m_state = 0, m_sc = 0, m_fc = 0, m_wait = 0;
  bit m_to = 0;
  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .mem_busy(mem_busy), .cnt_clr(cnt_clr), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .timeout(timeout)
  );
  always #5 clk = ~clk;
  function automatic bit lw();
    return ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
  endfunction
  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (reset) return 2'b00;
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction
  function automatic logic [6:0] exp_ctl();
    if (reset) return 7'b00000_11;
    if (mem_busy) return 7'b11111_00;
    if (PCSrcE) return 7'b00000_11;
    if (lw()) return 7'b11000_01;
    return 7'b00000_00;
  endfunction
  task automatic idle();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, PCSrcE, mem_busy, cnt_clr} = '0;
    ResultSrcE = 2'b00;
  endtask
  task automatic model_reset();
    m_state = 0; m_sc = 0; m_fc = 0; m_wait = 0; m_to = 0;
  endtask
  task automatic tick();
    logic [6:0] e;
    int ns, nw;
    bit rst, clr, busy;
    e = exp_ctl();
    rst = reset; clr = cnt_clr; busy = mem_busy;
    ns = busy ? 3 : PCSrcE ? 2 : lw() ? 1 : 0;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_state = ns;
      nw = busy ? ((m_wait + 1 > 255) ? 255 : m_wait + 1) : 0;
      m_wait = nw;
      if (clr) begin m_sc = 0; m_fc = 0; m_to = 0; end
      else begin
        if (e[6] && m_sc < 65535) m_sc++;
        if (e[0] && m_fc < 65535) m_fc++;
        if (nw >= 255) m_to = 1;
      end
    end
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    Rs1D = 5; Rs2D = 2; Rs1E = 3; Rs2E = 3; RdE = 5; RdM = 3; RdW = 3;
    RegWriteM = 1; RegWriteW = 1; ResultSrcE = 2'b01; PCSrcE = 1; mem_busy = 1; cnt_clr = 0;
    tick(); tick();
    cmp++; if (ctl !== 7'b00000_11) begin errs++; $display("FAIL reset_ctl: got %b want 0000011", ctl); end
    cmp++; if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin errs++; $display("FAIL reset_fwd: got %b/%b want 00/00", ForwardAE, ForwardBE); end
    cmp++; if ({state, stall_cnt, flush_cnt, timeout} !== 35'd0) begin errs++; $display("FAIL reset_regs: got st=%0d sc=%0d fc=%0d to=%0d want all 0", state, stall_cnt, flush_cnt, timeout); end
    idle(); reset = 1'b0; model_reset();
    tick();
    cmp++; if (state !== 2'd0) begin errs++; $display("FAIL reset_release_state: got %0d want 0", state); end
  endtask
  task automatic test_forwarding();
    idle();
    RegWriteM = 1; RdM = 3; RegWriteW = 1; RdW = 3; Rs1E = 3; #1;
    cmp++; if (ForwardAE !== 2'b10) begin errs++; $display("FAIL fwd_mem_wins: got %b want 10", ForwardAE); end
    RdM = 0; #1;
    cmp++; if (ForwardAE !== 2'b01) begin errs++; $display("FAIL fwd_wb: got %b want 01", ForwardAE); end
    Rs2E = 0; RdW = 0; #1;
    cmp++; if (ForwardBE !== 2'b00) begin errs++; $display("FAIL fwd_x0: got %b want 00", ForwardBE); end
    tick();
    for (int i = 0; i < 40; i++) begin
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom); #1;
      cmp++; if (ForwardAE !== fwd(Rs1E) || ForwardBE !== fwd(Rs2E)) begin errs++; $display("FAIL fwd_rand: got %b/%b want %b/%b", ForwardAE, ForwardBE, fwd(Rs1E), fwd(Rs2E)); end
      tick();
    end
    idle(); tick();
  endtask
  task automatic test_load_stall();
    int sc0, fc0;
    idle(); ResultSrcE = 2'b01; RdE = 5; Rs1D = 5; #1;
    sc0 = m_sc; fc0 = m_fc;
    cmp++; if (ctl !== 7'b11000_01) begin errs++; $display("FAIL lw_ctl: got %b want 1100001", ctl); end
    tick(); idle(); #1;
    cmp++; if (ctl !== 7'b00000_00) begin errs++; $display("FAIL lw_one_cycle: got %b want 0000000", ctl); end
    cmp++; if (state !== 2'b01) begin errs++; $display("FAIL lw_state: got %b want 01", state); end
    cmp++; if (stall_cnt !== 16'(sc0 + 1) || flush_cnt !== 16'(fc0 + 1)) begin errs++; $display("FAIL lw_cnt: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, sc0 + 1, fc0 + 1); end
    tick();
  endtask
  task automatic test_branch_vs_load();
    int sc0, fc0;
    idle(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; PCSrcE = 1; #1;
    sc0 = m_sc; fc0 = m_fc;
    cmp++; if (ctl !== 7'b00000_11) begin errs++; $display("FAIL br_ctl: got %b want 0000011", ctl); end
    tick(); idle(); #1;
    cmp++; if (state !== 2'b10) begin errs++; $display("FAIL br_state: got %b want 10", state); end
    cmp++; if (stall_cnt !== 16'(sc0) || flush_cnt !== 16'(fc0 + 1)) begin errs++; $display("FAIL br_cnt: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, sc0, fc0 + 1); end
    tick();
  endtask
  task automatic test_memwait();
    int sc0;
    idle(); mem_busy = 1; PCSrcE = 1; sc0 = m_sc;
    for (int i = 0; i < 3; i++) begin
      #1;
      cmp++; if (ctl !== 7'b11111_00) begin errs++; $display("FAIL mw_ctl%0d: got %b want 1111100", i, ctl); end
      tick();
    end
    mem_busy = 0; #1;
    cmp++; if (ctl !== 7'b00000_11) begin errs++; $display("FAIL mw_release: got %b want 0000011", ctl); end
    cmp++; if (state !== 2'b11 || stall_cnt !== 16'(sc0 + 3)) begin errs++; $display("FAIL mw_regs: got st=%b sc=%0d want 11/%0d", state, stall_cnt, sc0 + 3); end
    tick(); idle(); #1;
    cmp++; if (state !== 2'b10) begin errs++; $display("FAIL mw_redirect: got %b want 10", state); end
    tick();
  endtask
  task automatic test_timeout();
    idle(); mem_busy = 1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254) begin cmp++; if (timeout !== 1'b0) begin errs++; $display("FAIL to_early: got %b want 0", timeout); end end
      if (i == 255) begin cmp++; if (timeout !== 1'b1) begin errs++; $display("FAIL to_set: got %b want 1", timeout); end end
    end
    mem_busy = 0; tick(); tick();
    cmp++; if (timeout !== 1'b1) begin errs++; $display("FAIL to_sticky: got %b want 1", timeout); end
    cnt_clr = 1; tick(); cnt_clr = 0;
    cmp++; if ({timeout, stall_cnt, flush_cnt} !== 33'd0) begin errs++; $display("FAIL to_clr: got to=%b sc=%0d fc=%0d want 0", timeout, stall_cnt, flush_cnt); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom); ResultSrcE = 2'($urandom);
      PCSrcE = ($urandom_range(0, 5) == 0); mem_busy = ($urandom_range(0, 3) == 0);
      cnt_clr = ($urandom_range(0, 39) == 0); #1;
      cmp++; if (ctl !== exp_ctl()) begin errs++; $display("FAIL rnd_ctl%0d: got %b want %b", i, ctl, exp_ctl()); end
      cmp++; if (ForwardAE !== fwd(Rs1E) || ForwardBE !== fwd(Rs2E)) begin errs++; $display("FAIL rnd_fwd%0d: got %b/%b want %b/%b", i, ForwardAE, ForwardBE, fwd(Rs1E), fwd(Rs2E)); end
      tick();
      cmp++; if (state !== 2'(m_state) || stall_cnt !== 16'(m_sc) || flush_cnt !== 16'(m_fc) || timeout !== m_to) begin errs++; $display("FAIL rnd_regs%0d: got st=%0d sc=%0d fc=%0d to=%b want %0d/%0d/%0d/%b", i, state, stall_cnt, flush_cnt, timeout, m_state, m_sc, m_fc, m_to); end
    end
    idle(); tick();
  endtask
  task automatic test_saturation_and_reset();
    idle(); mem_busy = 1;
    repeat (65540) tick();
    cmp++; if (stall_cnt !== 16'hFFFF || m_sc != 65535) begin errs++; $display("FAIL sat_reach: got %h want FFFF", stall_cnt); end
    repeat (5) tick();
    cmp++; if (stall_cnt !== 16'hFFFF) begin errs++; $display("FAIL sat_hold: got %h want FFFF", stall_cnt); end
    #2 reset = 1; model_reset(); #1;
    cmp++; if (ctl !== 7'b00000_11) begin errs++; $display("FAIL rst_mw_ctl: got %b want 0000011", ctl); end
    cmp++; if ({state, stall_cnt, flush_cnt, timeout} !== 35'd0) begin errs++; $display("FAIL rst_mw_regs: got st=%0d sc=%0d fc=%0d to=%b want 0", state, stall_cnt, flush_cnt, timeout); end
    tick(); reset = 0; idle(); tick();
    cmp++; if (state !== 2'b00 || stall_cnt !== 16'd0) begin errs++; $display("FAIL rst_mw_after: got st=%0d sc=%0d want 0/0", state, stall_cnt); end
    ResultSrcE = 2'b01; RdE = 4; Rs1D = 4; tick();
    cmp++; if (state !== 2'b01) begin errs++; $display("FAIL ld_state: got %b want 01", state); end
    #2 reset = 1; model_reset(); #1;
    cmp++; if (state !== 2'b00 || ctl !== 7'b00000_11 || stall_cnt !== 16'd0) begin errs++; $display("FAIL rst_ld: got st=%0d ctl=%b sc=%0d want 0/0000011/0", state, ctl, stall_cnt); end
    tick(); reset = 0; idle(); tick();
  endtask
  initial begin
    idle();
    test_reset();
    test_forwarding();
    test_load_stall();
    test_branch_vs_load();
    test_memwait();
    test_timeout();
    test_random();
    test_saturation_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports Rs1D, Rs2D, input, 5 each, source registers of the instruction in Decode.
REQ-004 SHALL have ports Rs1E, Rs2E, RdE, input, 5 each, sources and destination of the instruction in Execute.
REQ-005 SHALL have ports RdM, RdW, input, 5 each, destinations in Memory and Writeback.
REQ-006 SHALL have ports RegWriteM, RegWriteW, input, 1 each, write enables in Memory and Writeback.
REQ-007 SHALL have port ResultSrcE, input, 2, result select in Execute; 2'b01 means load.
REQ-008 SHALL have port PCSrcE, input, 1, taken branch or jump resolved in Execute.
REQ-009 SHALL have port mem_busy, input, 1, data memory not ready.
REQ-010 SHALL have port cnt_clr, input, 1, synchronous clear of the performance counters.
REQ-011 SHALL have ports ForwardAE, ForwardBE, output, 2 each, operand mux select: 00 register file, 01 Writeback, 10 Memory.
REQ-012 SHALL have ports StallF, StallD, StallE, StallM, StallW, output, 1 each, hold the stage register.
REQ-013 SHALL have ports FlushD, FlushE, output, 1 each; FlushE drives the CLR_E clear of the Decode-to-Execute register.
REQ-014 SHALL have ports state, output, 2; stall_cnt, flush_cnt, output, 16 each; timeout, output, 1.

Function
REQ-015 Forwarding SHALL be combinational: ForwardAE=10 if RegWriteM, RdM!=0 and RdM==Rs1E; else 01 if RegWriteW, RdW!=0 and RdW==Rs1E; else 00; ForwardBE likewise on Rs2E; Memory wins over Writeback.
REQ-016 lwStall SHALL be ResultSrcE==01 and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
REQ-017 The FSM SHALL have states RUN=00, LDSTALL=01, REDIRECT=10, MEMWAIT=11; next-state priority is mem_busy, then PCSrcE, then lwStall, then RUN.
REQ-018 In MEMWAIT (mem_busy=1, any state):
- all five Stall outputs = 1.
- FlushD = FlushE = 0.
- PCSrcE and lwStall are ignored. They are re-evaluated on the first cycle mem_busy=0, because the Execute contents are held.
REQ-019 With mem_busy=0 and PCSrcE=1: FlushD = FlushE = 1, all Stalls = 0, next state REDIRECT; this applies even if lwStall=1.
REQ-020 With mem_busy=0, PCSrcE=0 and lwStall=1: StallF = StallD = 1, FlushE = 1, StallE/M/W = 0, FlushD = 0, next state LDSTALL.
REQ-021 Otherwise all Stall and Flush outputs SHALL be 0 and the next state is RUN.
REQ-022 Stall and Flush outputs SHALL be Mealy: combinational from the current inputs. state shows the registered condition of the previous cycle.
REQ-023 stall_cnt SHALL increment on every cycle with StallF=1; flush_cnt SHALL increment on every cycle with FlushE=1.
REQ-024 Both counters SHALL saturate at 16'hFFFF and not wrap.
REQ-025 cnt_clr SHALL zero both counters on the next edge and take priority over increment.
REQ-026 An 8-bit wait counter SHALL count consecutive mem_busy cycles and reset to 0 when mem_busy=0.
REQ-027 When the wait counter reaches 255, timeout SHALL set on that edge. timeout is sticky and is cleared only by reset or cnt_clr.

Reset
REQ-028 While reset=1:
- state = RUN; stall_cnt, flush_cnt, wait counter and timeout = 0.
- FlushD = FlushE = 1; all Stalls = 0; ForwardAE = ForwardBE = 00.
REQ-029 Reset asserted mid-MEMWAIT or mid-LDSTALL SHALL abandon the operation immediately with no counter increment. The first cycle after reset releases is RUN.

Verification
REQ-030 Load x5 in Execute (ResultSrcE=01, RdE=5), Rs1D=5 -> StallF=StallD=FlushE=1 for exactly 1 cycle, state=01 next, stall_cnt+1, flush_cnt+1.
REQ-031 RegWriteM=1, RdM=3, RegWriteW=1, RdW=3, Rs1E=3 -> ForwardAE=10. The same with RdM=0 -> ForwardAE=01. Rs2E=0 with RdW=0 -> ForwardBE=00.
REQ-032 PCSrcE=1 together with lwStall=1 -> FlushD=FlushE=1, StallF=0, state=10 next, flush_cnt+1, stall_cnt unchanged.
REQ-033 mem_busy=1 for 3 cycles with PCSrcE=1 held -> all Stalls=1 and Flushes=0 for 3 cycles; 4th cycle FlushD=FlushE=1, stall_cnt+3.
REQ-034 mem_busy=1 for 300 cycles -> timeout=1 after the 255th busy cycle and remains 1 after mem_busy falls; cnt_clr clears it.
REQ-035 Preload stall_cnt to FFFF, then stall -> stays FFFF. Assert reset mid-MEMWAIT -> all Stalls=0 at once, counters 0, state 00.
